// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style text LCD sequencer.
// Holds the LCD command bytes, the sequencer state encoding and a helper
// that returns the power-up command list entry for a given index.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP  = 8'h0E;  // display on, cursor on
  localparam logic [7:0] CMD_ENTRY = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_CLEAR = 8'h01;  // clear display, needs extra settle time
  localparam logic [7:0] CMD_LINE1 = 8'h80;  // DDRAM address of line 1, column 0
  localparam logic [7:0] CMD_LINE2 = 8'hC0;  // DDRAM address of line 2, column 0

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ADDR1 = 3'd2;
  localparam logic [2:0] ST_DATA1 = 3'd3;
  localparam logic [2:0] ST_ADDR2 = 3'd4;
  localparam logic [2:0] ST_DATA2 = 3'd5;

  typedef enum logic [2:0] {
    INIT  = ST_INIT,
    IDLE  = ST_IDLE,
    ADDR1 = ST_ADDR1,
    DATA1 = ST_DATA1,
    ADDR2 = ST_ADDR2,
    DATA2 = ST_DATA2
  } lcd_state_e;

  localparam int N_INIT     = 4;   // entries in the power-up command list
  localparam int LINE_CHARS = 16;  // characters per display line

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return CMD_FUNC;
      2'd1:    return CMD_DISP;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One LCD bus write per slot of T_SLOT cycles.
// Ports:
//   LCDCLK, PRESETn   clock, synchronous active-low reset
//   start             begin a slot with rs/data; accepted whether idle or on
//                     the done cycle, so slots can be chained without a gap
//   rs, data          register-select and byte for the slot being started
//   done              high on the last cycle (c = T_SLOT-1) of a slot
//   idle              no slot in progress
//   LCD_RS, LCD_EN, LCD_DATA  registered LCD pins
module lcd_byte_writer #(
  parameter int T_SETUP = 200,
  parameter int T_PULSE = 1600,
  parameter int T_SLOT  = 2001
) (
  input  logic       LCDCLK,
  input  logic       PRESETn,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       done,
  output logic       idle,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA
);

  localparam int CW = $clog2(T_SLOT);

  logic [CW-1:0] cnt_q, cnt_n;
  logic          active_q, active_n;
  logic          en_q, en_n;
  logic          rs_q;
  logic [7:0]    data_q;

  // EN is decoded from the next counter value so the pin itself is a flop.
  always_comb begin
    active_n = active_q;
    cnt_n    = cnt_q;
    if (start) begin
      active_n = 1'b1;
      cnt_n    = '0;
    end else if (active_q) begin
      if (cnt_q == CW'(T_SLOT - 1)) active_n = 1'b0;
      else                          cnt_n    = cnt_q + CW'(1);
    end
    en_n = active_n && (cnt_n >= CW'(T_SETUP)) && (cnt_n < CW'(T_SETUP + T_PULSE));
  end

  always_ff @(posedge LCDCLK) begin
    if (!PRESETn) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      active_q <= active_n;
      cnt_q    <= cnt_n;
      en_q     <= en_n;
      if (start) begin
        rs_q   <= rs;
        data_q <= data;
      end
    end
  end

  assign done     = active_q && (cnt_q == CW'(T_SLOT - 1));
  assign idle     = !active_q;
  assign LCD_RS   = rs_q;
  assign LCD_EN   = en_q;
  assign LCD_DATA = data_q;

endmodule

// File: rtl/lcd_text_sequencer.sv
// Drives a 16x2 HD44780-style text LCD from a 32-character frame buffer.
// After reset it issues the init command list, waits out the clear command,
// then writes each accepted frame as: 0x80, 16 chars, 0xC0, 16 chars.
// Ports:
//   LCDCLK, PRESETn        clock, synchronous active-low reset
//   frame_data[255:0]      32 ASCII chars, [255:248] = line 1 col 0,
//                          [127:120] = line 2 col 0
//   frame_valid/ready      frame handshake (see below)
//   busy                   high in every state other than IDLE
//   LCD_RS/RW/EN/DATA      LCD pins; RW is tied low (write only)
//   dbg_state              current sequencer state (lcd_state_e encoding)
// Handshake: a frame transfers on a rising LCDCLK edge where frame_valid and
// frame_ready are both high. frame_ready is registered, is high only in IDLE
// and drops the cycle after a transfer; frame_data is sampled only at that
// edge, so it may change freely at any other time.
module lcd_text_sequencer
  import lcd_pkg::*;
#(
  parameter int T_SETUP = 200,
  parameter int T_PULSE = 1600,
  parameter int T_SLOT  = 2001,
  parameter int T_CLEAR = 4000
) (
  input  logic         LCDCLK,
  input  logic         PRESETn,
  input  logic [255:0] frame_data,
  input  logic         frame_valid,
  output logic         frame_ready,
  output logic         busy,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic         LCD_EN,
  output logic [7:0]   LCD_DATA,
  output logic [2:0]   dbg_state
);

  localparam int WW = $clog2(T_CLEAR);

  lcd_state_e         state_q, state_n;
  logic [4:0]         idx_q, idx_n;
  logic [WW-1:0]      wait_q, wait_n;
  logic [31:0][7:0]   frame_buf;  // element 31 = line 1 col 0, element 0 = line 2 col 15
  logic               ready_q, busy_q;
  logic               load_buf;
  logic               wr_start, wr_rs, wr_done, wr_idle;
  logic [7:0]         wr_data;

  // Each slot's done cycle launches the following byte in the same cycle,
  // so the byte writer never idles inside a command list or a frame.
  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    wait_n   = wait_q;
    load_buf = 1'b0;
    wr_start = 1'b0;
    wr_rs    = 1'b0;
    wr_data  = 8'h00;
    case (state_q)
      INIT: begin
        if (idx_q < 5'(N_INIT)) begin
          if (wr_idle) begin
            // first command after reset
            wr_start = 1'b1;
            wr_data  = init_cmd(idx_q[1:0]);
          end else if (wr_done) begin
            if (idx_q == 5'(N_INIT - 1)) begin
              idx_n  = 5'(N_INIT);  // clear issued: settle with EN low
              wait_n = '0;
            end else begin
              idx_n    = idx_q + 5'd1;
              wr_start = 1'b1;
              wr_data  = init_cmd(idx_n[1:0]);
            end
          end
        end else if (wait_q == WW'(T_CLEAR - 1)) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          wait_n = wait_q + WW'(1);
        end
      end
      IDLE: begin
        if (frame_valid && ready_q) begin
          load_buf = 1'b1;
          state_n  = ADDR1;
          wr_start = 1'b1;
          wr_data  = CMD_LINE1;
        end
      end
      ADDR1: begin
        if (wr_done) begin
          state_n  = DATA1;
          idx_n    = '0;
          wr_start = 1'b1;
          wr_rs    = 1'b1;
          wr_data  = frame_buf[31];
        end
      end
      DATA1: begin
        if (wr_done) begin
          if (idx_q == 5'(LINE_CHARS - 1)) begin
            state_n  = ADDR2;
            idx_n    = '0;
            wr_start = 1'b1;
            wr_data  = CMD_LINE2;
          end else begin
            idx_n    = idx_q + 5'd1;
            wr_start = 1'b1;
            wr_rs    = 1'b1;
            wr_data  = frame_buf[5'd30 - idx_q];
          end
        end
      end
      ADDR2: begin
        if (wr_done) begin
          state_n  = DATA2;
          idx_n    = '0;
          wr_start = 1'b1;
          wr_rs    = 1'b1;
          wr_data  = frame_buf[15];
        end
      end
      DATA2: begin
        if (wr_done) begin
          if (idx_q == 5'(LINE_CHARS - 1)) begin
            state_n = IDLE;
            idx_n   = '0;
          end else begin
            idx_n    = idx_q + 5'd1;
            wr_start = 1'b1;
            wr_rs    = 1'b1;
            wr_data  = frame_buf[5'd14 - idx_q];
          end
        end
      end
      default: begin
        state_n = INIT;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge LCDCLK) begin
    if (!PRESETn) begin
      state_q   <= INIT;
      idx_q     <= '0;
      wait_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      frame_buf <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      wait_q  <= wait_n;
      ready_q <= (state_n == IDLE);
      busy_q  <= (state_n != IDLE);
      if (load_buf) frame_buf <= frame_data;
    end
  end

  lcd_byte_writer #(
    .T_SETUP (T_SETUP),
    .T_PULSE (T_PULSE),
    .T_SLOT  (T_SLOT)
  ) u_writer (
    .LCDCLK   (LCDCLK),
    .PRESETn  (PRESETn),
    .start    (wr_start),
    .rs       (wr_rs),
    .data     (wr_data),
    .done     (wr_done),
    .idle     (wr_idle),
    .LCD_RS   (LCD_RS),
    .LCD_EN   (LCD_EN),
    .LCD_DATA (LCD_DATA)
  );

  assign frame_ready = ready_q;
  assign busy        = busy_q;
  assign LCD_RW      = 1'b0;
  assign dbg_state   = state_q;

endmodule
